// File: rtl/i2c_slave_if_if.sv
// I2C slave bus bundle: pad-side SCL/SDA plus the user-side byte handshakes.
interface i2c_slave_if_if;
   logic       scl_i;
   logic       scl_t;
   logic       scl_o;
   logic       sda_i;
   logic       sda_t;
   logic       sda_o;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       ack_en;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_req;
   logic       tx_underrun;
   logic       busy;
   logic       rw;
   logic       start_det;
   logic       stop_det;
   logic       master_nack;

   modport slave (
      input  scl_i, sda_i, ack_en, tx_data, tx_valid,
      output scl_t, scl_o, sda_t, sda_o, rx_data, rx_valid, tx_req,
             tx_underrun, busy, rw, start_det, stop_det, master_nack
   );

   modport master (
      output scl_i, sda_i, ack_en, tx_data, tx_valid,
      input  scl_t, scl_o, sda_t, sda_o, rx_data, rx_valid, tx_req,
             tx_underrun, busy, rw, start_det, stop_det, master_nack
   );
endinterface

// File: rtl/i2c_slave_if.sv
// Byte-level I2C target: filtered SCL/SDA, START/STOP detection, fixed
// 7-bit address match, ACK/NACK and byte handshakes to user logic.
module i2c_slave_if #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h50,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic           clk,
   input  logic           resetn,
   i2c_slave_if_if.slave  bus
);

   localparam int unsigned CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   // index 0 = SCL, index 1 = SDA
   logic [1:0]       w_pins;
   logic [1:0]       r_sync1, r_sync2, r_filt, r_filt_d, r_rise, r_fall;
   logic [CNT_W-1:0] r_cnt [2];

   logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0] w_tx_byte;

   state_t     r_state;
   logic [3:0] r_bitcnt;
   logic [7:0] r_shift;
   logic [7:0] r_tx_shift;
   logic [7:0] r_rx_data;
   logic       r_sda_t, r_busy, r_rw;
   logic       r_rx_valid, r_tx_req, r_tx_underrun;
   logic       r_start_det, r_stop_det, r_master_nack;

   assign w_pins     = {bus.sda_i, bus.scl_i};
   assign w_scl      = r_filt[0];
   assign w_sda      = r_filt[1];
   assign w_scl_rise = r_rise[0];
   assign w_scl_fall = r_fall[0];
   // SDA edges while filtered SCL is high are bus conditions, not data
   assign w_start    = r_fall[1] & w_scl;
   assign w_stop     = r_rise[1] & w_scl;
   assign w_tx_byte  = bus.tx_valid ? bus.tx_data : 8'hFF;

   // Synchronize, glitch-filter and edge-detect both pad inputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1  <= 2'b11;
         r_sync2  <= 2'b11;
         r_filt   <= 2'b11;
         r_filt_d <= 2'b11;
         r_rise   <= 2'b00;
         r_fall   <= 2'b00;
         r_cnt[0] <= '0;
         r_cnt[1] <= '0;
      end else begin
         r_sync1  <= w_pins;
         r_sync2  <= r_sync1;
         r_filt_d <= r_filt;
         r_rise   <= r_filt & ~r_filt_d;
         r_fall   <= ~r_filt & r_filt_d;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_filt[i] <= r_sync2[i];
               r_cnt[i]  <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Protocol FSM; SDA drive updates one clk after the registered SCL fall
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= IDLE;
         r_bitcnt      <= '0;
         r_shift       <= '0;
         r_tx_shift    <= '1;
         r_rx_data     <= '0;
         r_sda_t       <= 1'b1;
         r_busy        <= 1'b0;
         r_rw          <= 1'b0;
         r_rx_valid    <= 1'b0;
         r_tx_req      <= 1'b0;
         r_tx_underrun <= 1'b0;
         r_start_det   <= 1'b0;
         r_stop_det    <= 1'b0;
         r_master_nack <= 1'b0;
      end else begin
         r_rx_valid    <= 1'b0;
         r_tx_req      <= 1'b0;
         r_tx_underrun <= 1'b0;
         r_start_det   <= 1'b0;
         r_stop_det    <= 1'b0;
         r_master_nack <= 1'b0;
         if (w_start) begin
            r_state     <= ADDR;
            r_bitcnt    <= '0;
            r_sda_t     <= 1'b1;
            r_start_det <= 1'b1;
         end else if (w_stop) begin
            r_state    <= IDLE;
            r_bitcnt   <= '0;
            r_sda_t    <= 1'b1;
            r_busy     <= 1'b0;
            r_stop_det <= 1'b1;
         end else begin
            case (r_state)
               ADDR: begin
                  if (w_scl_rise) begin
                     r_shift  <= {r_shift[6:0], w_sda};
                     r_bitcnt <= r_bitcnt + 4'd1;
                  end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                     r_bitcnt <= '0;
                     if (r_shift[7:1] == SLAVE_ADDR) begin
                        r_state <= ADDR_ACK;
                        r_sda_t <= 1'b0;
                        r_busy  <= 1'b1;
                        r_rw    <= r_shift[0];
                     end else begin
                        r_state <= IGNORE;
                        r_busy  <= 1'b0;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (w_scl_rise) begin
                     r_tx_req <= r_rw;
                  end else if (w_scl_fall) begin
                     if (r_rw) begin
                        r_state       <= RD_DATA;
                        r_sda_t       <= w_tx_byte[7];
                        r_tx_shift    <= {w_tx_byte[6:0], 1'b1};
                        r_tx_underrun <= ~bus.tx_valid;
                     end else begin
                        r_state <= WR_DATA;
                        r_sda_t <= 1'b1;
                     end
                  end
               end
               WR_DATA: begin
                  if (w_scl_rise) begin
                     r_shift  <= {r_shift[6:0], w_sda};
                     r_bitcnt <= r_bitcnt + 4'd1;
                     if (r_bitcnt == 4'd7) begin
                        r_rx_data  <= {r_shift[6:0], w_sda};
                        r_rx_valid <= 1'b1;
                     end
                  end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                     r_bitcnt <= '0;
                     if (bus.ack_en) begin
                        r_state <= WR_ACK;
                        r_sda_t <= 1'b0;
                     end else begin
                        r_state <= IGNORE;
                     end
                  end
               end
               WR_ACK: begin
                  if (w_scl_fall) begin
                     r_state <= WR_DATA;
                     r_sda_t <= 1'b1;
                  end
               end
               RD_DATA: begin
                  if (w_scl_rise) begin
                     r_bitcnt <= r_bitcnt + 4'd1;
                  end else if (w_scl_fall) begin
                     if (r_bitcnt == 4'd8) begin
                        r_bitcnt <= '0;
                        r_sda_t  <= 1'b1;
                        r_state  <= RD_ACK;
                     end else begin
                        r_sda_t    <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                     end
                  end
               end
               RD_ACK: begin
                  if (w_scl_rise) begin
                     if (!w_sda) begin
                        r_tx_req <= 1'b1;
                     end else begin
                        r_master_nack <= 1'b1;
                        r_state       <= IGNORE;
                     end
                  end else if (w_scl_fall) begin
                     r_state       <= RD_DATA;
                     r_sda_t       <= w_tx_byte[7];
                     r_tx_shift    <= {w_tx_byte[6:0], 1'b1};
                     r_tx_underrun <= ~bus.tx_valid;
                  end
               end
               default: begin
                  r_sda_t <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.scl_t       = 1'b1;
   assign bus.scl_o       = 1'b0;
   assign bus.sda_o       = 1'b0;
   assign bus.sda_t       = r_sda_t;
   assign bus.rx_data     = r_rx_data;
   assign bus.rx_valid    = r_rx_valid;
   assign bus.tx_req      = r_tx_req;
   assign bus.tx_underrun = r_tx_underrun;
   assign bus.busy        = r_busy;
   assign bus.rw          = r_rw;
   assign bus.start_det   = r_start_det;
   assign bus.stop_det    = r_stop_det;
   assign bus.master_nack = r_master_nack;

endmodule

// File: tb/tb_i2c_slave_if.sv
// Directed bench for i2c_slave_if: a bit-banged I2C master on a wired-AND bus.
module tb_i2c_slave_if;

   localparam int Q = 10;  // quarter SCL period in clk cycles

   logic clk = 1'b0;
   logic resetn;
   logic m_scl, m_sda;

   always #5 clk = ~clk;

   i2c_slave_if_if bus();

   assign bus.scl_i = m_scl;
   assign bus.sda_i = m_sda & bus.sda_t;

   i2c_slave_if #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Monotonic event counters; tests compare deltas
   int n_rxv = 0, n_txreq = 0, n_und = 0, n_start = 0, n_stop = 0, n_nack = 0, n_drv = 0;
   logic [7:0] rx_log [64];

   always @(posedge clk) begin
      if (bus.rx_valid) begin
         if (n_rxv < 64) rx_log[n_rxv] <= bus.rx_data;
         n_rxv <= n_rxv + 1;
      end
      if (bus.tx_req)      n_txreq <= n_txreq + 1;
      if (bus.tx_underrun) n_und   <= n_und + 1;
      if (bus.start_det)   n_start <= n_start + 1;
      if (bus.stop_det)    n_stop  <= n_stop + 1;
      if (bus.master_nack) n_nack  <= n_nack + 1;
      if (!bus.sda_t)      n_drv   <= n_drv + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_x(input logic b, input logic glitch, output logic line);
      wq(Q); m_sda = b; wq(Q); m_scl = 1'b1;
      if (glitch) begin
         wq(6); m_scl = 1'b0; wq(2); m_scl = 1'b1; wq(2);
      end else begin
         wq(Q);
      end
      line = bus.sda_i;
      wq(Q); m_scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
      logic l;
      for (int i = 7; i >= 0; i--) bit_x(d[i], logic'(i == gbit), l);
      bit_x(1'b1, 1'b0, ack);
   endtask

   task automatic recv_byte(input logic mack, input logic [7:0] nd, input logic nv,
                            output logic [7:0] d);
      logic l;
      for (int i = 7; i >= 0; i--) begin
         bit_x(1'b1, 1'b0, l);
         d[i] = l;
      end
      bus.tx_data  = nd;
      bus.tx_valid = nv;
      bit_x(~mack, 1'b0, l);
   endtask

   task automatic i2c_start();
      m_sda = 1'b0; wq(Q); m_scl = 1'b0;
   endtask

   task automatic i2c_rstart();
      wq(Q); m_sda = 1'b1; wq(Q); m_scl = 1'b1; wq(Q); m_sda = 1'b0; wq(Q); m_scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wq(Q); m_sda = 1'b0; wq(Q); m_scl = 1'b1; wq(Q); m_sda = 1'b1; wq(Q);
   endtask

   initial begin
      logic a0, a1, a2, a3;
      logic [7:0] d0, d1;
      int b_rx, b_tr, b_un, b_st, b_sp, b_nk, b_dv;

      resetn       = 1'b0;
      m_scl        = 1'b1;
      m_sda        = 1'b1;
      bus.ack_en   = 1'b1;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      wq(3);
      chk("rst_sda_t", 32'(bus.sda_t), 32'd1);
      chk("rst_scl_t", 32'(bus.scl_t), 32'd1);
      chk("rst_sda_o", 32'(bus.sda_o), 32'd0);
      chk("rst_scl_o", 32'(bus.scl_o), 32'd0);
      chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rw", 32'(bus.rw), 32'd0);
      resetn = 1'b1;
      wq(2 * Q);

      // Write A5, 3C to our address
      b_rx = n_rxv; b_st = n_start; b_sp = n_stop;
      i2c_start();
      send_byte(8'hA0, -1, a0);
      chk("t1_busy_match", 32'(bus.busy), 32'd1);
      send_byte(8'hA5, -1, a1);
      send_byte(8'h3C, -1, a2);
      chk("t1_ack_addr", 32'(a0), 32'd0);
      chk("t1_ack_b0", 32'(a1), 32'd0);
      chk("t1_ack_b1", 32'(a2), 32'd0);
      chk("t1_busy_pre_stop", 32'(bus.busy), 32'd1);
      i2c_stop();
      chk("t1_rx_cnt", 32'(n_rxv - b_rx), 32'd2);
      chk("t1_rx0", 32'(rx_log[b_rx]), 32'hA5);
      chk("t1_rx1", 32'(rx_log[b_rx + 1]), 32'h3C);
      chk("t1_rx_data", 32'(bus.rx_data), 32'h3C);
      chk("t1_busy_post", 32'(bus.busy), 32'd0);
      chk("t1_start_cnt", 32'(n_start - b_st), 32'd1);
      chk("t1_stop_cnt", 32'(n_stop - b_sp), 32'd1);

      // Foreign address 0x51
      b_rx = n_rxv; b_dv = n_drv;
      i2c_start();
      send_byte(8'hA2, -1, a0);
      send_byte(8'h77, -1, a1);
      chk("t2_nack_addr", 32'(a0), 32'd1);
      chk("t2_nack_data", 32'(a1), 32'd1);
      chk("t2_no_drive", 32'(n_drv - b_dv), 32'd0);
      chk("t2_busy", 32'(bus.busy), 32'd0);
      i2c_stop();
      chk("t2_no_rx", 32'(n_rxv - b_rx), 32'd0);

      // Read 96 (ACK), 0F (NACK)
      b_tr = n_txreq; b_nk = n_nack; b_un = n_und;
      bus.tx_data = 8'h96; bus.tx_valid = 1'b1;
      i2c_start();
      send_byte(8'hA1, -1, a0);
      chk("t3_ack_addr", 32'(a0), 32'd0);
      chk("t3_rw", 32'(bus.rw), 32'd1);
      recv_byte(1'b1, 8'h0F, 1'b1, d0);
      recv_byte(1'b0, 8'h00, 1'b0, d1);
      chk("t3_byte0", 32'(d0), 32'h96);
      chk("t3_byte1", 32'(d1), 32'h0F);
      chk("t3_tx_req_cnt", 32'(n_txreq - b_tr), 32'd2);
      chk("t3_nack_cnt", 32'(n_nack - b_nk), 32'd1);
      chk("t3_no_underrun", 32'(n_und - b_un), 32'd0);
      chk("t3_sda_released", 32'(bus.sda_t), 32'd1);
      i2c_stop();

      // Write with user NACK on second data byte
      b_rx = n_rxv;
      i2c_start();
      send_byte(8'hA0, -1, a0);
      send_byte(8'h11, -1, a1);
      bus.ack_en = 1'b0;
      send_byte(8'h22, -1, a2);
      bus.ack_en = 1'b1;
      chk("t4_rx_after_22", 32'(n_rxv - b_rx), 32'd2);
      send_byte(8'h33, -1, a3);
      chk("t4_ack_11", 32'(a1), 32'd0);
      chk("t4_nack_22", 32'(a2), 32'd1);
      chk("t4_ignore_33", 32'(a3), 32'd1);
      chk("t4_rx_cnt", 32'(n_rxv - b_rx), 32'd2);
      chk("t4_rx0", 32'(rx_log[b_rx]), 32'h11);
      chk("t4_rx1", 32'(rx_log[b_rx + 1]), 32'h22);
      i2c_stop();

      // Write then repeated START into read with underrun
      b_st = n_start; b_tr = n_txreq; b_un = n_und;
      bus.tx_valid = 1'b0; bus.tx_data = 8'h5A;
      i2c_start();
      send_byte(8'hA0, -1, a0);
      chk("t5_rw0", 32'(bus.rw), 32'd0);
      send_byte(8'h10, -1, a1);
      i2c_rstart();
      send_byte(8'hA1, -1, a2);
      chk("t5_rw1", 32'(bus.rw), 32'd1);
      chk("t5_tx_req_slot", 32'(n_txreq - b_tr), 32'd1);
      recv_byte(1'b0, 8'h00, 1'b0, d0);
      chk("t5_acks", 32'({a0, a1, a2}), 32'd0);
      chk("t5_underrun_byte", 32'(d0), 32'hFF);
      chk("t5_underrun_cnt", 32'(n_und - b_un), 32'd1);
      chk("t5_start_cnt", 32'(n_start - b_st), 32'd2);
      i2c_stop();

      // SCL glitch during a data bit
      b_rx = n_rxv;
      i2c_start();
      send_byte(8'hA0, -1, a0);
      send_byte(8'h5A, 4, a1);
      chk("t6_glitch_ack", 32'(a1), 32'd0);
      chk("t6_glitch_rx", 32'(rx_log[b_rx]), 32'h5A);
      i2c_stop();

      // Async reset while driving a read 0
      bus.tx_data = 8'h00; bus.tx_valid = 1'b1;
      i2c_start();
      send_byte(8'hA1, -1, a0);
      wq(Q);
      chk("t7_driving", 32'(bus.sda_t), 32'd0);
      resetn = 1'b0;
      #1;
      chk("t7_async_release", 32'(bus.sda_t), 32'd1);
      chk("t7_busy_clr", 32'(bus.busy), 32'd0);
      chk("t7_rw_clr", 32'(bus.rw), 32'd0);
      wq(2);
      m_scl = 1'b1; m_sda = 1'b1;
      resetn = 1'b1;
      bus.tx_valid = 1'b0;
      wq(4 * Q);
      i2c_start();
      send_byte(8'hA0, -1, a0);
      chk("t7_post_reset_ack", 32'(a0), 32'd0);
      i2c_stop();
      chk("t7_post_busy", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
